xpar_uart_tx: RTL and testbench
===============================

Name: xpar_uart_tx

Overview:
- Memory-mapped UART transmitter on the picoversat external parallel interface (the par_* bus).
- Acts as the responder to the controller's par_re/par_we strobes.
- Bytes written by software go into a TX FIFO and are serialized 8N1 (LSB first) on a single output line.
- Software reads status and programs the baud divisor through the same interface.

Parameters:
- DATA_W, 32, width of par_out/par_in data words.
- PAR_ADDR_W, 12, width of par_addr; only the low 2 bits are decoded, upper bits ignored (aliasing).
- FIFO_LOG2, 3, log2 of TX FIFO depth (8 entries).
- DIV_RST, 434, reset value of baud divisor (clocks per bit).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- par_addr  input  PAR_ADDR_W  word address from controller.
- par_out  input  DATA_W  write data from controller.
- par_we  input  1  write strobe, one cycle per access.
- par_re  input  1  read strobe.
- par_in  output  DATA_W  read data to controller.
- tx  output  1  serial line, registered, idle high.

Behaviour:
- Register map on par_addr[1:0]:
  - 0 TXDATA (W): push par_out[7:0].
  - 1 STATUS (R/W).
  - 2 DIV (R/W): bits[15:0].
  - 3 reserved: reads 0, writes ignored.
- STATUS read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[3+FIFO_LOG2+1:4] fill count, other bits 0.
- STATUS write with par_out[3]=1 clears overflow; other bits ignored.
- Read path is combinational: par_in = selected register when par_re=1, else 0. Reads have no side effects.
- DIV: 16-bit, reset DIV_RST; a value of 0 is treated as 1.
  - A write mid-frame takes effect at the next bit-counter reload; the current bit is unaffected.
- FIFO:
  - A push when full is dropped and sets overflow, even if a pop occurs the same cycle (full is evaluated pre-edge).
  - A push when empty with a simultaneous pop cannot happen; the pop requires non-empty.
  - Pointers wrap modulo 2^FIFO_LOG2; count range is 0..2^FIFO_LOG2.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. When FIFO non-empty, pop the head into shift reg, go to START, tx=0 at that same edge.
  - START: hold for DIV clocks, then go to DATA with tx=shift[0].
  - DATA: each bit lasts DIV clocks; shift right. After bit 7's period, go to STOP with tx=1.
  - STOP: hold DIV clocks, then go to IDLE.
    - If FIFO is non-empty on that final clock, go directly to START (back-to-back frames, no idle gap).
- Latency: TXDATA write sampled at edge E, FIFO previously empty and FSM IDLE → tx falls at edge E+1. Each frame is exactly 10*DIV clocks.
- Bit counter is 16-bit down-counter reloaded with max(DIV,1)-1 at every bit boundary.
- Reset (any time, including mid-frame):
  - Asynchronously forces tx=1, FSM=IDLE, FIFO empty, overflow=0, DIV=DIV_RST.
  - Counters and shift reg go to 0.
  - par_in is combinational, so it reads STATUS=0x4 (empty) under par_re.
- Simultaneous par_we and par_re in the same cycle: the write takes effect at the edge; the read returns pre-edge values.

Optional Feature:
- Macro: XPAR_UART_PARITY_EN.
- Defined:
  - STATUS bit8 is R/W parity enable (reset 0).
  - When set, an even-parity bit is inserted between DATA and STOP via an extra PARITY state lasting DIV clocks; frame becomes 11*DIV clocks.
- Undefined:
  - No PARITY state; STATUS bit8 reads 0, writes ignored.
  - Frames are always 10*DIV clocks.

Test Plan:
- Reset:
  - rst pulse → tx=1, STATUS read = 0x00000004.
  - DIV read = 434.
- Single byte:
  - Write DIV=4, write TXDATA=0xA5.
  - tx low 1 edge later; then bits 1,0,1,0,0,1,0,1 each 4 clocks; stop high 4 clocks; 40 clocks total; busy clears after.
- FIFO full/overflow:
  - DIV=100, write 10 bytes back-to-back.
  - First byte pops immediately; 8 accepted into FIFO; 10th dropped.
  - STATUS shows full=1, overflow=1, count=8.
  - Write STATUS 0x8 → overflow=0.
- Back-to-back frames:
  - DIV=2, write 0x00 and 0xFF.
  - Second start bit immediately follows first stop bit, no idle cycle; total 40 clocks.
- Reset mid-frame:
  - Assert rst during DATA bit 3 of 0x55 → tx=1 same cycle (asynchronous).
  - FIFO empty; no further transitions after release.
- Parity (XPAR_UART_PARITY_EN):
  - Enable bit8, DIV=2, send 0x07 → parity bit 1 after bit 7; frame 22 clocks.
  - Send 0x03 → parity bit 0.

Source files
------------

// File: rtl/xpar_uart_tx.sv
// UART 8N1 transmitter on the picoversat par_* bus, with an 8-entry TX FIFO.
// Define XPAR_UART_PARITY_EN to add STATUS bit8 parity enable and an even-parity bit.
module xpar_uart_tx #(
  parameter int DATA_W     = 32,
  parameter int PAR_ADDR_W = 12,
  parameter int FIFO_LOG2  = 3,
  parameter int DIV_RST    = 434
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAR_ADDR_W-1:0] par_addr,
  input  logic [DATA_W-1:0]     par_out,
  input  logic                  par_we,
  input  logic                  par_re,
  output logic [DATA_W-1:0]     par_in,
  output logic                  tx
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_CNT = {1'b1, {FIFO_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic par_q, par_d;
  logic [15:0] div_q, div_d;
  logic ovf_q, ovf_d;
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0] count_q, count_d;
  logic [7:0] mem_q [DEPTH];

  logic [1:0] addr;
  logic wr_tx, wr_status, wr_div;
  logic full, empty, pop, do_push;
  logic [15:0] reload;
  logic [7:0] head;
  logic par_en;
  logic [DATA_W-1:0] status;
  logic unused_ok;

  assign addr = par_addr[1:0];
  assign wr_tx = par_we && (addr == 2'd0);
  assign wr_status = par_we && (addr == 2'd1);
  assign wr_div = par_we && (addr == 2'd2);

  assign full = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign do_push = wr_tx && !full;
  assign head = mem_q[rd_ptr_q];
  // A divisor of 0 behaves as 1: reload value is then 0.
  assign reload = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign tx = tx_q;
  assign unused_ok = ^{par_addr, par_out};

`ifdef XPAR_UART_PARITY_EN
  logic par_en_q, par_en_d;

  always_comb begin
    par_en_d = par_en_q;
    if (wr_status) par_en_d = par_out[8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_en_q <= 1'b0;
    else     par_en_q <= par_en_d;
  end

  assign par_en = par_en_q;
`else
  assign par_en = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    par_d   = par_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = ^head;
          cnt_d   = reload;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          cnt_d   = reload;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = reload;
          if (bit_q == 3'd7) begin
            if (par_en) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PAR: begin
        if (cnt_q == 16'd0) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          cnt_d   = reload;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          // Back-to-back frame: skip IDLE so no gap appears on the line.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = ^head;
            cnt_d   = reload;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    div_d    = div_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !pop) count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;
    if (wr_div) div_d = par_out[15:0];
    if (wr_status && par_out[3]) ovf_d = 1'b0;
    if (wr_tx && full) ovf_d = 1'b1;
  end

  always_comb begin
    status = '0;
    status[0] = (state_q != S_IDLE);
    status[1] = full;
    status[2] = empty;
    status[3] = ovf_q;
    status[4 +: FIFO_LOG2+1] = count_q;
    status[8] = par_en;
    par_in = '0;
    if (par_re) begin
      unique case (addr)
        2'd1:    par_in = status;
        2'd2:    par_in = {{(DATA_W-16){1'b0}}, div_q};
        default: par_in = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= par_out[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      par_q    <= 1'b0;
      div_q    <= 16'(DIV_RST);
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      par_q    <= par_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_xpar_uart_tx.sv
// Self-checking bench for xpar_uart_tx: register table plus serial-line scoreboard.
module tb_xpar_uart_tx;

  logic clk = 1'b0;
  logic rst;
  logic [11:0] par_addr;
  logic [31:0] par_out;
  logic par_we;
  logic par_re;
  logic [31:0] par_in;
  logic tx;

  int tot = 0;
  int bad = 0;
  int frames = 0;
  int div_tb = 434;
  bit par_tb = 1'b0;
  logic [7:0] sb[$];

  xpar_uart_tx dut (
    .clk(clk), .rst(rst), .par_addr(par_addr), .par_out(par_out),
    .par_we(par_we), .par_re(par_re), .par_in(par_in), .tx(tx)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    tot++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endfunction

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    par_addr = a;
    par_out = d;
    par_we = 1'b1;
    @(negedge clk);
    par_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    sb.push_back(b);
    wr(12'h0, {24'h0, b});
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    par_addr = a;
    par_re = 1'b1;
    #1 v = par_in;
    par_re = 1'b0;
  endtask

  // Serial monitor: decodes each frame and compares against the scoreboard.
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    logic ok, ab, pb;
    int nb, dv;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      nb = par_tb ? 11 : 10;
      dv = div_tb;
      ok = 1'b1;
      ab = 1'b0;
      pb = 1'b0;
      d = '0;
      for (int b = 0; b < nb && !ab; b++) begin
        for (int c = 0; c < dv; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst !== 1'b0) begin
            ab = 1'b1;
            break;
          end
          if (b == 0) begin
            if (tx !== 1'b0) ok = 1'b0;
          end else if (b <= 8) begin
            if (c == 0) d[b-1] = tx;
            else if (tx !== d[b-1]) ok = 1'b0;
          end else if (b == 9 && nb == 11) begin
            if (c == 0) pb = tx;
            else if (tx !== pb) ok = 1'b0;
          end else begin
            if (tx !== 1'b1) ok = 1'b0;
          end
        end
      end
      if (!ab) begin
        frames++;
        if (sb.size() == 0) begin
          tot++;
          bad++;
          $display("FAIL unexpected_frame: got %h want none", d);
        end else begin
          e = sb.pop_front();
          chk("frame_data", {24'h0, d}, {24'h0, e});
          chk("frame_shape", {31'h0, ok}, 32'h1);
          if (nb == 11) chk("parity_bit", {31'h0, pb}, {31'h0, ^e});
        end
      end
    end
  end

  typedef struct {
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        do_wr;
    logic [11:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [31:0] v;
    int chg;
    logic last;
    int exp_frames;

`ifdef XPAR_UART_PARITY_EN
    vt[0] = '{12'h002, 32'h0000_1234, 1'b1, 12'h002, 32'h0000_1234};
    vt[1] = '{12'h002, 32'hABCD_FFFF, 1'b1, 12'h002, 32'h0000_FFFF};
    vt[2] = '{12'h003, 32'hFFFF_FFFF, 1'b1, 12'h003, 32'h0};
    vt[3] = '{12'h000, 32'h0,         1'b0, 12'h405, 32'h4};
    vt[4] = '{12'h001, 32'hFFFF_FFF7, 1'b1, 12'h001, 32'h104};
    vt[5] = '{12'h001, 32'h0,         1'b1, 12'h001, 32'h4};
    vt[6] = '{12'h802, 32'd434,       1'b1, 12'h002, 32'd434};
`else
    vt[0] = '{12'h002, 32'h0000_1234, 1'b1, 12'h002, 32'h0000_1234};
    vt[1] = '{12'h002, 32'hABCD_FFFF, 1'b1, 12'h002, 32'h0000_FFFF};
    vt[2] = '{12'h003, 32'hFFFF_FFFF, 1'b1, 12'h003, 32'h0};
    vt[3] = '{12'h000, 32'h0,         1'b0, 12'h405, 32'h4};
    vt[4] = '{12'h001, 32'hFFFF_FFF7, 1'b1, 12'h001, 32'h4};
    vt[5] = '{12'h001, 32'h0,         1'b1, 12'h001, 32'h4};
    vt[6] = '{12'h802, 32'd434,       1'b1, 12'h002, 32'd434};
`endif

    rst = 1'b1;
    par_addr = '0;
    par_out = '0;
    par_we = 1'b0;
    par_re = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    rd(12'h1, v);
    chk("rst_status", v, 32'h4);
    rd(12'h2, v);
    chk("rst_div", v, 32'd434);
    @(negedge clk);
    rst = 1'b0;
    chk("no_re_zero", par_in, 32'h0);

    // Register table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (vt[i].do_wr) wr(vt[i].waddr, vt[i].wdata);
      rd(vt[i].raddr, v);
      chk($sformatf("reg_vec%0d", i), v, vt[i].exp);
    end

    // Simultaneous write and read: read sees pre-edge value
    @(negedge clk);
    par_addr = 12'h2;
    par_out = 32'd7;
    par_we = 1'b1;
    par_re = 1'b1;
    #1 chk("rw_same_cycle_old", par_in, 32'd434);
    @(negedge clk);
    par_we = 1'b0;
    rd(12'h2, v);
    chk("rw_same_cycle_new", v, 32'd7);

    // Single byte, DIV=4
    wr(12'h2, 32'd4);
    div_tb = 4;
    send(8'hA5);
    chk("lat_pre", {31'h0, tx}, 32'h1);
    @(negedge clk);
    chk("lat_fall", {31'h0, tx}, 32'h0);
    repeat (39) @(negedge clk);
    rd(12'h1, v);
    chk("a5_busy_last", {31'h0, v[0]}, 32'h1);
    @(negedge clk);
    rd(12'h1, v);
    chk("a5_idle_after", v, 32'h4);

    // DIV=0 behaves as 1
    wr(12'h2, 32'd0);
    div_tb = 1;
    send(8'h3C);
    @(negedge clk);
    repeat (9) @(negedge clk);
    rd(12'h1, v);
    chk("div0_busy_last", {31'h0, v[0]}, 32'h1);
    @(negedge clk);
    rd(12'h1, v);
    chk("div0_idle_after", v, 32'h4);

    // FIFO full and overflow, DIV=100
    wr(12'h2, 32'd100);
    div_tb = 100;
    for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
    wr(12'h0, 32'h0000_00EE);
    rd(12'h1, v);
    chk("ovf_status", v, 32'h8B);
    wr(12'h1, 32'h8);
    rd(12'h1, v);
    chk("ovf_clear", v, 32'h83);
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      rd(12'h1, v);
      if (v == 32'h4) break;
    end
    chk("ovf_drain", v, 32'h4);

    // Back-to-back frames, DIV=2
    wr(12'h2, 32'd2);
    div_tb = 2;
    send(8'h00);
    send(8'hFF);
    chk("b2b_first_start", {31'h0, tx}, 32'h0);
    repeat (19) @(negedge clk);
    chk("b2b_stop", {31'h0, tx}, 32'h1);
    @(negedge clk);
    chk("b2b_second_start", {31'h0, tx}, 32'h0);
    repeat (19) @(negedge clk);
    rd(12'h1, v);
    chk("b2b_busy_last", {31'h0, v[0]}, 32'h1);
    @(negedge clk);
    rd(12'h1, v);
    chk("b2b_idle_after", v, 32'h4);

`ifdef XPAR_UART_PARITY_EN
    // Even parity, DIV=2: 11-bit frames
    wr(12'h1, 32'h100);
    rd(12'h1, v);
    chk("par_enable", v, 32'h104);
    par_tb = 1'b1;
    send(8'h07);
    @(negedge clk);
    repeat (21) @(negedge clk);
    rd(12'h1, v);
    chk("par07_busy_last", {31'h0, v[0]}, 32'h1);
    @(negedge clk);
    rd(12'h1, v);
    chk("par07_idle_after", v, 32'h104);
    send(8'h03);
    @(negedge clk);
    repeat (22) @(negedge clk);
    rd(12'h1, v);
    chk("par03_idle_after", v, 32'h104);
    wr(12'h1, 32'h0);
    par_tb = 1'b0;
`endif

    // Reset mid-frame during data bit 3 of 0x55
    wr(12'h2, 32'd4);
    div_tb = 4;
    send(8'h55);
    wr(12'h0, 32'h11);
    repeat (17) @(negedge clk);
    chk("mid_bit3_low", {31'h0, tx}, 32'h0);
    #1 rst = 1'b1;
    #1 chk("mid_rst_async_tx", {31'h0, tx}, 32'h1);
    sb.delete();
    @(negedge clk);
    rd(12'h1, v);
    chk("mid_rst_status", v, 32'h4);
    @(negedge clk);
    rst = 1'b0;
    chg = 0;
    last = tx;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== last || tx !== 1'b1) chg++;
      last = tx;
    end
    chk("mid_quiet_after", chg, 0);
    rd(12'h1, v);
    chk("mid_status_after", v, 32'h4);
    rd(12'h2, v);
    chk("mid_div_after", v, 32'd434);

    // Scoreboard drained, expected number of frames seen
`ifdef XPAR_UART_PARITY_EN
    exp_frames = 15;
`else
    exp_frames = 13;
`endif
    chk("sb_empty", sb.size(), 0);
    chk("frame_count", frames, exp_frames);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
